// File: rtl/memory_controller_pkg.sv
// Shared address map, store-size encodings and UART FSM states for the memory controller.
package memory_controller_pkg;

    localparam logic [31:0] IO_BASE        = 32'h8000_0000;
    localparam logic [31:0] GPIO_OUT_ADDR  = IO_BASE + 32'h00;
    localparam logic [31:0] GPIO_DIR_ADDR  = IO_BASE + 32'h04;
    localparam logic [31:0] GPIO_IN_ADDR   = IO_BASE + 32'h08;
    localparam logic [31:0] UART_TX_ADDR   = IO_BASE + 32'h10;
    localparam logic [31:0] UART_STAT_ADDR = IO_BASE + 32'h14;

    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_BYTE = 3'b100;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_WORD = 3'b001;

    typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_e;

endpackage

// File: rtl/memory_controller_uart_tx.sv
// Transmit-only 8N1 UART, LSB first; start requests arriving while busy are dropped.
module uart_tx
    import memory_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e      state;
    logic [CW-1:0]  cnt;
    logic [3:0]     idx;
    logic [7:0]     shreg;

    // idx counts frame bits 0..9; the start bit goes out on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '1;
            busy  <= 1'b0;
            txd   <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        state <= TX_SEND;
                        shreg <= data;
                        cnt   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        txd   <= 1'b0;
                    end
                end
                TX_SEND: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt <= '0;
                        if (idx == 4'd9) begin
                            state <= TX_IDLE;
                            busy  <= 1'b0;
                            txd   <= 1'b1;
                        end else begin
                            // ones shift in behind the data, so bit 9 is the stop bit
                            idx   <= idx + 4'd1;
                            txd   <= shreg[0];
                            shreg <= {1'b1, shreg[7:1]};
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_controller.sv
// RAM with independent fetch port, GPIO and optional UART (MEMCTRL_UART_EN) on one data bus.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int RAM_WORDS    = 1024,
    parameter     INIT_FILE    = "",
    parameter int GPIO_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            write_enable,
    input  logic [31:0]           addr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    input  logic [31:0]           iaddr,
    output logic [31:0]           inst,
    inout  wire  [GPIO_WIDTH-1:0] gpio,
    output logic                  uart_txd
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [3:0][7:0] mem [RAM_WORDS];

    logic [AW-1:0]   widx, fidx;
    logic [3:0]      lane_en;
    logic [3:0][7:0] lane_data;
    logic            ram_sel, io_word_we;
    logic [31:0]     ram_rdata, io_rdata;

    assign widx       = addr[AW+1:2];
    assign fidx       = iaddr[AW+1:2];
    assign ram_sel    = ~addr[31];
    assign io_word_we = addr[31] && (write_enable == WE_WORD);

    logic unused_iaddr;
    assign unused_iaddr = ^{iaddr[31:AW+2], iaddr[1:0]};

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = data_in;
        case (write_enable)
            WE_BYTE: begin
                lane_en   = 4'b0001 << addr[1:0];
                lane_data = {4{data_in[7:0]}};
            end
            WE_HALF: begin
                lane_en   = addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{data_in[15:0]}};
            end
            WE_WORD: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_sel) begin
            for (int l = 0; l < 4; l++)
                if (lane_en[l]) mem[widx][l] <= lane_data[l];
        end
    end

    assign ram_rdata = mem[widx];
    assign inst      = mem[fidx];

    // GPIO registers and the two-flop input synchroniser
    logic [GPIO_WIDTH-1:0]      gpio_out, gpio_dir;
    logic [1:0][GPIO_WIDTH-1:0] sync_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out  <= '0;
            gpio_dir  <= '0;
            sync_pipe <= '0;
        end else begin
            sync_pipe <= {sync_pipe[0], gpio};
            if (io_word_we && addr == GPIO_OUT_ADDR) gpio_out <= data_in[GPIO_WIDTH-1:0];
            if (io_word_we && addr == GPIO_DIR_ADDR) gpio_dir <= data_in[GPIO_WIDTH-1:0];
        end
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        assign gpio[i] = gpio_dir[i] ? gpio_out[i] : 1'bz;
    end

    logic uart_busy;
`ifdef MEMCTRL_UART_EN
    logic uart_start;
    assign uart_start = io_word_we && (addr == UART_TX_ADDR);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .start (uart_start),
        .data  (data_in[7:0]),
        .busy  (uart_busy),
        .txd   (uart_txd)
    );
`else
    assign uart_busy = 1'b0;
    assign uart_txd  = 1'b1;
`endif

    always_comb begin
        io_rdata = 32'h0;
        case (addr)
            GPIO_OUT_ADDR:  io_rdata = 32'(gpio_out);
            GPIO_DIR_ADDR:  io_rdata = 32'(gpio_dir);
            GPIO_IN_ADDR:   io_rdata = 32'(sync_pipe[1]);
            UART_STAT_ADDR: io_rdata = {31'h0, uart_busy};
            default:        io_rdata = 32'h0;
        endcase
    end

    // RAM loads are right-aligned; peripheral reads return the whole register.
    assign data_out = ram_sel ? (ram_rdata >> {addr[1:0], 3'b000}) : io_rdata;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench: RAM store/load vector table, then GPIO, UART and reset sequences.
module tb_memory_controller;
    import memory_controller_pkg::*;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  write_enable = WE_NONE;
    logic [31:0] addr = 32'h0, data_in = 32'h0, iaddr = 32'h0;
    logic [31:0] data_out, inst;
    logic        uart_txd;
    wire  [7:0]  gpio;
    logic [7:0]  ext_en = 8'h00, ext_val = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    for (genvar i = 0; i < 8; i++) begin : g_ext
        assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    memory_controller #(
        .RAM_WORDS(1024), .INIT_FILE(""), .GPIO_WIDTH(8), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .write_enable(write_enable), .addr(addr),
        .data_in(data_in), .data_out(data_out), .iaddr(iaddr), .inst(inst),
        .gpio(gpio), .uart_txd(uart_txd)
    );

    typedef struct {
        logic [2:0]  we;
        logic [31:0] addr, din, raddr, iaddr, exp_d, exp_i;
    } vec_t;

    vec_t vt[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] we, input logic [31:0] d);
        addr = a; write_enable = we; data_in = d;
        tick();
        write_enable = WE_NONE;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = data_out;
    endtask

    logic [31:0] r;
    logic [9:0]  frame;

    initial begin
        vt[0]  = '{WE_WORD, 32'h100,        32'hDEADBEEF, 32'h100,        32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[1]  = '{WE_NONE, 32'h0,          32'h0,        32'h101,        32'h100, 32'h00DEADBE, 32'hDEADBEEF};
        vt[2]  = '{WE_NONE, 32'h0,          32'h0,        32'h103,        32'h100, 32'h000000DE, 32'hDEADBEEF};
        vt[3]  = '{WE_BYTE, 32'h102,        32'h0000005A, 32'h100,        32'h100, 32'hDE5ABEEF, 32'hDE5ABEEF};
        vt[4]  = '{WE_HALF, 32'h102,        32'h00001234, 32'h100,        32'h100, 32'h1234BEEF, 32'h1234BEEF};
        vt[5]  = '{WE_HALF, 32'h103,        32'hAB005678, 32'h100,        32'h100, 32'h5678BEEF, 32'h5678BEEF};
        vt[6]  = '{WE_BYTE, 32'h100,        32'hFFFFFF11, 32'h100,        32'h100, 32'h5678BE11, 32'h5678BE11};
        vt[7]  = '{WE_WORD, 32'h1000,       32'hCAFEF00D, 32'h0,          32'h0,   32'hCAFEF00D, 32'hCAFEF00D};
        vt[8]  = '{WE_WORD, 32'h004,        32'h11223344, 32'h1006,       32'h4,   32'h00001122, 32'h11223344};
        vt[9]  = '{WE_WORD, 32'h80000100,   32'hFFFFFFFF, 32'h80000100,   32'h100, 32'h00000000, 32'h5678BE11};
        vt[10] = '{3'b011,  32'h100,        32'h00000000, 32'h100,        32'h102, 32'h5678BE11, 32'h5678BE11};
        vt[11] = '{WE_WORD, GPIO_DIR_ADDR,  32'h0000000F, GPIO_DIR_ADDR,  32'h100, 32'h0000000F, 32'h5678BE11};
        vt[12] = '{WE_WORD, GPIO_OUT_ADDR,  32'h000000A5, GPIO_OUT_ADDR,  32'h100, 32'h000000A5, 32'h5678BE11};
        vt[13] = '{WE_BYTE, GPIO_OUT_ADDR,  32'h000000FF, GPIO_OUT_ADDR,  32'h100, 32'h000000A5, 32'h5678BE11};

        // reset state
        #1;
        chk("reset_txd", {31'h0, uart_txd}, 32'h1);
        rd(GPIO_OUT_ADDR, r); chk("reset_gpio_out", r, 32'h0);
        rd(GPIO_DIR_ADDR, r); chk("reset_gpio_dir", r, 32'h0);
        rd(UART_STAT_ADDR, r); chk("reset_busy", r, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            store(vt[i].addr, vt[i].we, vt[i].din);
            addr = vt[i].raddr; iaddr = vt[i].iaddr;
            #1;
            chk($sformatf("vec%0d_data", i), data_out, vt[i].exp_d);
            chk($sformatf("vec%0d_inst", i), inst, vt[i].exp_i);
        end

        // same-cycle store and load: old value before the edge, new after
        store(32'h200, WE_WORD, 32'h11111111);
        iaddr = 32'h200;
        addr = 32'h200; write_enable = WE_WORD; data_in = 32'h22222222;
        #1;
        chk("rw_before", data_out, 32'h11111111);
        chk("inst_before", inst, 32'h11111111);
        tick();
        write_enable = WE_NONE;
        chk("rw_after", data_out, 32'h22222222);
        chk("inst_after", inst, 32'h22222222);

        // GPIO: dir=0F, out=A5 -> low nibble driven, upper pins driven by bench
        ext_en = 8'hF0; ext_val = 8'h00;
        tick(); tick(); tick();
        chk("gpio_pins_low", {28'h0, gpio[3:0]}, 32'h5);
        rd(GPIO_IN_ADDR, r); chk("gpio_in_settled", r, 32'h05);
        ext_val = 8'hC0;
        tick();
        rd(GPIO_IN_ADDR, r); chk("gpio_in_1cyc", r, 32'h05);
        tick();
        rd(GPIO_IN_ADDR, r); chk("gpio_in_2cyc", r, 32'hC5);

`ifdef MEMCTRL_UART_EN
        frame = {1'b1, 8'h41, 1'b0};
        store(UART_TX_ADDR, WE_WORD, 32'h41);
        addr = UART_STAT_ADDR;
        for (int k = 0; k < 10 * CPB; k++) begin
            #1;
            chk($sformatf("txd_c%0d", k), {31'h0, uart_txd}, {31'h0, frame[k / CPB]});
            chk($sformatf("busy_c%0d", k), data_out, 32'h1);
            if (k == 5) begin
                addr = UART_TX_ADDR; write_enable = WE_WORD; data_in = 32'hFF;
                tick();
                write_enable = WE_NONE; addr = UART_STAT_ADDR;
            end else begin
                tick();
            end
        end
        #1;
        chk("busy_done", data_out, 32'h0);
        chk("txd_idle", {31'h0, uart_txd}, 32'h1);
        tick(); tick();
        chk("drop_txd_idle", {31'h0, uart_txd}, 32'h1);
        rd(UART_STAT_ADDR, r); chk("drop_busy", r, 32'h0);

        // reset in the middle of a frame
        store(UART_TX_ADDR, WE_WORD, 32'h00);
        tick(); tick(); tick(); tick(); tick();
        chk("midframe_txd", {31'h0, uart_txd}, 32'h0);
`else
        store(UART_TX_ADDR, WE_WORD, 32'h00);
        rd(UART_STAT_ADDR, r); chk("nouart_stat", r, 32'h0);
        chk("nouart_txd", {31'h0, uart_txd}, 32'h1);
        tick(); tick();
        chk("nouart_txd2", {31'h0, uart_txd}, 32'h1);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("rst_txd", {31'h0, uart_txd}, 32'h1);
        rd(UART_STAT_ADDR, r); chk("rst_busy", r, 32'h0);
        rd(GPIO_DIR_ADDR, r); chk("rst_dir", r, 32'h0);
        rd(GPIO_OUT_ADDR, r); chk("rst_out", r, 32'h0);
        rd(GPIO_IN_ADDR, r); chk("rst_sync", r, 32'h0);
        rd(32'h100, r); chk("rst_ram_keep", r, 32'h5678BE11);
        tick();
        rst = 1'b0;
        ext_en = 8'hFF; ext_val = 8'h3C;
        tick(); tick();
        rd(GPIO_IN_ADDR, r); chk("post_rst_gpio_in", r, 32'h3C);
        chk("post_rst_txd", {31'h0, uart_txd}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
